// File: rtl/cpu_issue_scoreboard_pkg.sv
// Shared CPU definitions used by the issue scoreboard: register-file geometry and issue FSM states.
package cpu_issue_scoreboard_pkg;

    localparam int REG_IDX_W = 5;
    localparam int REG_COUNT = 32;

    typedef enum logic [1:0] {
        READY       = 2'd0,
        WAIT_HAZARD = 2'd1,
        WAIT_EXEC   = 2'd2
    } issueState_e;

endpackage

// File: rtl/cpu_scoreboard_hazard.sv
// Combinational hazard check: a flagged nonzero source with writes in flight, or a saturated destination.
// With CPU_SCOREBOARD_BYPASS_EN, a writeback retiring a source's last pending write clears that source now.
module cpu_scoreboard_hazard
    import cpu_issue_scoreboard_pkg::*;
#(
    parameter int CNT_W    = 2,
    parameter int MAX_PEND = 3
) (
    input  logic [REG_COUNT-1:0][CNT_W-1:0] cnt_i,
    input  logic [2:0]                      haveRs_i,
    input  logic [REG_IDX_W-1:0]            rs1_i,
    input  logic [REG_IDX_W-1:0]            rs2_i,
    input  logic [REG_IDX_W-1:0]            rs3_i,
    input  logic [REG_IDX_W-1:0]            rd_i,
    input  logic                            writesRd_i,
    input  logic                            wbValid_i,
    input  logic [REG_IDX_W-1:0]            wbRd_i,
    output logic                            hazard_o
);

    logic [2:0][REG_IDX_W-1:0] srcIdx;
    logic [2:0]                srcBusy;
    logic                      rdFull;

    assign srcIdx = {rs3_i, rs2_i, rs1_i};

    always_comb begin
        srcBusy = '0;
        for (int s = 0; s < 3; s++) begin
            if (haveRs_i[s] && (srcIdx[s] != '0) && (cnt_i[srcIdx[s]] != '0)) begin
                srcBusy[s] = 1'b1;
`ifdef CPU_SCOREBOARD_BYPASS_EN
                if (wbValid_i && (wbRd_i == srcIdx[s]) && (cnt_i[srcIdx[s]] == CNT_W'(1))) begin
                    srcBusy[s] = 1'b0;
                end
`endif
            end
        end
    end

`ifndef CPU_SCOREBOARD_BYPASS_EN
    logic unusedWb;
    assign unusedWb = ^{wbValid_i, wbRd_i};
`endif

    assign rdFull   = writesRd_i && (rd_i != '0) && (cnt_i[rd_i] == CNT_W'(MAX_PEND));
    assign hazard_o = (|srcBusy) || rdFull;

endmodule

// File: rtl/cpu_issue_scoreboard.sv
// Issue scoreboard: holds one decoded instruction until its operands are free and execute is ready.
// Optional build macro CPU_SCOREBOARD_BYPASS_EN lets a retiring writeback clear a source hazard in its own cycle.
module cpu_issue_scoreboard
    import cpu_issue_scoreboard_pkg::*;
#(
    parameter int TAG_W    = 1,
    parameter int MAX_PEND = 3
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [TAG_W-1:0]     i_tag,
    input  logic [2:0]           i_have_rs,
    input  logic [REG_IDX_W-1:0] i_rs1,
    input  logic [REG_IDX_W-1:0] i_rs2,
    input  logic [REG_IDX_W-1:0] i_rs3,
    input  logic [REG_IDX_W-1:0] i_rd,
    input  logic                 i_writes_rd,
    input  logic                 i_execute_busy,
    input  logic                 i_wb_valid,
    input  logic [REG_IDX_W-1:0] i_wb_rd,
    input  logic                 i_flush,
    output logic [TAG_W-1:0]     o_issue_tag,
    output logic                 o_stall,
    output logic                 o_hazard,
    output logic [6:0]           o_pending,
    output logic                 o_fault
);

    localparam int CNT_W = $clog2(MAX_PEND + 1);

    issueState_e                     state_q;
    logic [TAG_W-1:0]                lastTag_q, issueTag_q, heldTag_q;
    logic [2:0]                      heldHaveRs_q;
    logic [REG_IDX_W-1:0]            heldRs1_q, heldRs2_q, heldRs3_q, heldRd_q;
    logic                            heldWritesRd_q;
    logic                            stall_q, hazard_q, fault_q;
    logic [6:0]                      pending_q, pending_d;
    logic [REG_COUNT-1:0][CNT_W-1:0] cnt_q, cnt_d;

    logic                 inReady, newTag, haveCand, hazard, issueNow;
    logic                 incRd, wbHit, decWb, wbToIdle;
    logic [TAG_W-1:0]     evalTag;
    logic [2:0]           evalHaveRs;
    logic [REG_IDX_W-1:0] evalRs1, evalRs2, evalRs3, evalRd;
    logic                 evalWritesRd;

    // In READY the candidate is the instruction on the decode inputs; otherwise the latched one.
    assign inReady      = (state_q == READY);
    assign newTag       = (i_tag != lastTag_q);
    assign haveCand     = !inReady || newTag;
    assign evalTag      = inReady ? i_tag       : heldTag_q;
    assign evalHaveRs   = inReady ? i_have_rs   : heldHaveRs_q;
    assign evalRs1      = inReady ? i_rs1       : heldRs1_q;
    assign evalRs2      = inReady ? i_rs2       : heldRs2_q;
    assign evalRs3      = inReady ? i_rs3       : heldRs3_q;
    assign evalRd       = inReady ? i_rd        : heldRd_q;
    assign evalWritesRd = inReady ? i_writes_rd : heldWritesRd_q;

    cpu_scoreboard_hazard #(
        .CNT_W    (CNT_W),
        .MAX_PEND (MAX_PEND)
    ) u_hazard (
        .cnt_i      (cnt_q),
        .haveRs_i   (evalHaveRs),
        .rs1_i      (evalRs1),
        .rs2_i      (evalRs2),
        .rs3_i      (evalRs3),
        .rd_i       (evalRd),
        .writesRd_i (evalWritesRd),
        .wbValid_i  (i_wb_valid),
        .wbRd_i     (i_wb_rd),
        .hazard_o   (hazard)
    );

    assign issueNow = !i_flush && haveCand && !hazard && !i_execute_busy;
    assign incRd    = issueNow && evalWritesRd && (evalRd != '0);
    assign wbHit    = i_wb_valid && (i_wb_rd != '0);
    assign decWb    = wbHit && (cnt_q[i_wb_rd] != '0);
    assign wbToIdle = wbHit && (cnt_q[i_wb_rd] == '0);

    // Increment is applied first so a same-register inc/dec pair nets to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (i_flush) begin
            cnt_d = '0;
        end else begin
            if (incRd) cnt_d[evalRd]  = cnt_d[evalRd] + CNT_W'(1);
            if (decWb) cnt_d[i_wb_rd] = cnt_d[i_wb_rd] - CNT_W'(1);
        end
        cnt_d[0] = '0;
    end

    assign pending_d = i_flush ? 7'd0 : (pending_q + 7'(incRd) - 7'(decWb));

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q     <= '0;
            pending_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            if (!i_flush && wbToIdle) fault_q <= 1'b1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q        <= READY;
            lastTag_q      <= '0;
            issueTag_q     <= '0;
            heldTag_q      <= '0;
            heldHaveRs_q   <= '0;
            heldRs1_q      <= '0;
            heldRs2_q      <= '0;
            heldRs3_q      <= '0;
            heldRd_q       <= '0;
            heldWritesRd_q <= 1'b0;
            stall_q        <= 1'b0;
            hazard_q       <= 1'b0;
        end else if (i_flush) begin
            state_q   <= READY;
            lastTag_q <= i_tag;
            stall_q   <= 1'b0;
            hazard_q  <= 1'b0;
        end else begin
            if (inReady && newTag) begin
                lastTag_q      <= i_tag;
                heldTag_q      <= i_tag;
                heldHaveRs_q   <= i_have_rs;
                heldRs1_q      <= i_rs1;
                heldRs2_q      <= i_rs2;
                heldRs3_q      <= i_rs3;
                heldRd_q       <= i_rd;
                heldWritesRd_q <= i_writes_rd;
            end
            if (issueNow) begin
                issueTag_q <= evalTag;
                state_q    <= READY;
                stall_q    <= 1'b0;
                hazard_q   <= 1'b0;
            end else if (haveCand) begin
                state_q  <= hazard ? WAIT_HAZARD : WAIT_EXEC;
                stall_q  <= 1'b1;
                hazard_q <= hazard;
            end
        end
    end

    assign o_issue_tag = issueTag_q;
    assign o_stall     = stall_q;
    assign o_hazard    = hazard_q;
    assign o_pending   = pending_q;
    assign o_fault     = fault_q;

endmodule

// File: tb/tb_cpu_issue_scoreboard.sv
// Self-checking bench for cpu_issue_scoreboard: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model of the scoreboard.
module tb_cpu_issue_scoreboard;

    localparam int TAG_W    = 4;
    localparam int MAX_PEND = 3;

    typedef struct packed {
        logic [2:0] haveRs;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rs3;
        logic [4:0] rd;
        logic       writesRd;
    } instr_t;

    logic             i_clock        = 1'b0;
    logic             i_reset        = 1'b0;
    logic [TAG_W-1:0] i_tag          = '0;
    logic [2:0]       i_have_rs      = '0;
    logic [4:0]       i_rs1          = '0;
    logic [4:0]       i_rs2          = '0;
    logic [4:0]       i_rs3          = '0;
    logic [4:0]       i_rd           = '0;
    logic             i_writes_rd    = 1'b0;
    logic             i_execute_busy = 1'b0;
    logic             i_wb_valid     = 1'b0;
    logic [4:0]       i_wb_rd        = '0;
    logic             i_flush        = 1'b0;
    logic [TAG_W-1:0] o_issue_tag;
    logic             o_stall;
    logic             o_hazard;
    logic [6:0]       o_pending;
    logic             o_fault;

    cpu_issue_scoreboard #(
        .TAG_W    (TAG_W),
        .MAX_PEND (MAX_PEND)
    ) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_tag          (i_tag),
        .i_have_rs      (i_have_rs),
        .i_rs1          (i_rs1),
        .i_rs2          (i_rs2),
        .i_rs3          (i_rs3),
        .i_rd           (i_rd),
        .i_writes_rd    (i_writes_rd),
        .i_execute_busy (i_execute_busy),
        .i_wb_valid     (i_wb_valid),
        .i_wb_rd        (i_wb_rd),
        .i_flush        (i_flush),
        .o_issue_tag    (o_issue_tag),
        .o_stall        (o_stall),
        .o_hazard       (o_hazard),
        .o_pending      (o_pending),
        .o_fault        (o_fault)
    );

    always #5 i_clock = ~i_clock;

    int               modelCnt [32];
    bit               modelHolding, modelWaitHaz, modelFault;
    instr_t           modelHeld;
    logic [TAG_W-1:0] modelLastTag, modelIssueTag, modelHeldTag;
    int               checks = 0;
    int               errors = 0;

    function automatic instr_t mkInstr(input logic [2:0] haveRs, input int rs1, input int rs2,
                                       input int rs3, input int rd, input logic wr);
        instr_t r;
        r.haveRs   = haveRs;
        r.rs1      = 5'(rs1);
        r.rs2      = 5'(rs2);
        r.rs3      = 5'(rs3);
        r.rd       = 5'(rd);
        r.writesRd = wr;
        return r;
    endfunction

    function automatic int modelPending();
        int sum = 0;
        for (int r = 0; r < 32; r++) sum += modelCnt[r];
        return sum;
    endfunction

    // An instruction must wait while any source it reads has writes outstanding,
    // or while its destination already has the maximum number of writes in flight.
    function automatic bit modelHazard(input instr_t ins, input logic wbv, input logic [4:0] wbr);
        logic [4:0] srcs [3];
        bit         h = 1'b0;
        srcs[0] = ins.rs1;
        srcs[1] = ins.rs2;
        srcs[2] = ins.rs3;
        for (int s = 0; s < 3; s++) begin
            if (ins.haveRs[s] && srcs[s] != 5'd0 && modelCnt[srcs[s]] > 0) begin
`ifdef CPU_SCOREBOARD_BYPASS_EN
                if (!(wbv && wbr == srcs[s] && modelCnt[srcs[s]] == 1)) h = 1'b1;
`else
                h = 1'b1;
`endif
            end
        end
        if (ins.writesRd && ins.rd != 5'd0 && modelCnt[ins.rd] >= MAX_PEND) h = 1'b1;
`ifndef CPU_SCOREBOARD_BYPASS_EN
        if (wbv && wbr == 5'd31 && h == 1'b0) h = 1'b0;
`endif
        return h;
    endfunction

    task automatic modelReset();
        for (int r = 0; r < 32; r++) modelCnt[r] = 0;
        modelHolding  = 1'b0;
        modelWaitHaz  = 1'b0;
        modelFault    = 1'b0;
        modelHeld     = '0;
        modelLastTag  = '0;
        modelIssueTag = '0;
        modelHeldTag  = '0;
    endtask

    task automatic modelStep();
        instr_t           cand;
        logic [TAG_W-1:0] candTag;
        bit               have, haz, issue;
        if (!i_reset) begin
            modelReset();
            return;
        end
        if (i_flush) begin
            for (int r = 0; r < 32; r++) modelCnt[r] = 0;
            modelHolding = 1'b0;
            modelWaitHaz = 1'b0;
            modelLastTag = i_tag;
            return;
        end
        have    = 1'b0;
        cand    = '0;
        candTag = '0;
        if (modelHolding) begin
            have    = 1'b1;
            cand    = modelHeld;
            candTag = modelHeldTag;
        end else if (i_tag != modelLastTag) begin
            have         = 1'b1;
            cand         = mkInstr(i_have_rs, int'(i_rs1), int'(i_rs2), int'(i_rs3), int'(i_rd), i_writes_rd);
            candTag      = i_tag;
            modelLastTag = i_tag;
        end
        haz   = have && modelHazard(cand, i_wb_valid, i_wb_rd);
        issue = have && !haz && !i_execute_busy;
        if (i_wb_valid && i_wb_rd != 5'd0) begin
            if (modelCnt[i_wb_rd] == 0) modelFault = 1'b1;
            else modelCnt[i_wb_rd]--;
        end
        if (issue) begin
            modelIssueTag = candTag;
            if (cand.writesRd && cand.rd != 5'd0) modelCnt[cand.rd]++;
        end
        modelHolding = have && !issue;
        modelWaitHaz = haz;
        modelHeld    = cand;
        modelHeldTag = candTag;
    endtask

    task automatic checkVal(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        checkVal("issue_tag", int'(o_issue_tag), int'(modelIssueTag));
        checkVal("stall",     int'(o_stall),     int'(modelHolding));
        checkVal("hazard",    int'(o_hazard),    int'(modelHolding && modelWaitHaz));
        checkVal("pending",   int'(o_pending),   modelPending());
        checkVal("fault",     int'(o_fault),     int'(modelFault));
    endtask

    task automatic applyStimulus(input logic [TAG_W-1:0] tag, input instr_t ins, input logic busy,
                                 input logic wbv, input logic [4:0] wbr, input logic fl);
        i_tag          = tag;
        i_have_rs      = ins.haveRs;
        i_rs1          = ins.rs1;
        i_rs2          = ins.rs2;
        i_rs3          = ins.rs3;
        i_rd           = ins.rd;
        i_writes_rd    = ins.writesRd;
        i_execute_busy = busy;
        i_wb_valid     = wbv;
        i_wb_rd        = wbr;
        i_flush        = fl;
    endtask

    task automatic cycle();
        @(posedge i_clock);
        modelStep();
        @(negedge i_clock);
        checkOutput();
    endtask

    function automatic instr_t randInstr();
        return mkInstr(3'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    endfunction

    function automatic logic [4:0] pickWb();
        int start = int'($urandom_range(1, 7));
        if ($urandom_range(0, 4) != 0) begin
            for (int k = 0; k < 7; k++) begin
                int r = ((start - 1 + k) % 7) + 1;
                if (modelCnt[r] > 0) return 5'(r);
            end
        end
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        instr_t           nop, addi5, add6, wr7, wr9, rd10;
        instr_t           curIns;
        logic [TAG_W-1:0] curTag;
        logic             busy, wbv, fl;
        logic [4:0]       wbr;

        nop   = mkInstr(3'b000, 0, 0, 0, 0, 1'b0);
        addi5 = mkInstr(3'b001, 0, 0, 0, 5, 1'b1);
        add6  = mkInstr(3'b011, 5, 1, 0, 6, 1'b1);
        wr7   = mkInstr(3'b000, 0, 0, 0, 7, 1'b1);
        wr9   = mkInstr(3'b000, 0, 0, 0, 9, 1'b1);
        rd10  = mkInstr(3'b001, 10, 0, 0, 20, 1'b1);

        modelReset();
        applyStimulus(4'd0, nop, 1'b0, 1'b0, 5'd0, 1'b0);
        cycle();
        cycle();
        checkVal("lit_rst_issue_tag", int'(o_issue_tag), 0);
        checkVal("lit_rst_stall",     int'(o_stall),     0);
        checkVal("lit_rst_hazard",    int'(o_hazard),    0);
        checkVal("lit_rst_pending",   int'(o_pending),   0);
        checkVal("lit_rst_fault",     int'(o_fault),     0);
        i_reset = 1'b1;

        // Dependent ADD waits on ADDI's destination until its writeback.
        applyStimulus(4'd1, addi5, 1'b0, 1'b0, 5'd0, 1'b0);
        cycle();
        checkVal("lit_addi_issue_tag", int'(o_issue_tag), 1);
        checkVal("lit_addi_pending",   int'(o_pending),   1);
        applyStimulus(4'd2, add6, 1'b0, 1'b0, 5'd0, 1'b0);
        cycle();
        checkVal("lit_add_hazard",    int'(o_hazard),    1);
        checkVal("lit_add_stall",     int'(o_stall),     1);
        checkVal("lit_add_issue_tag", int'(o_issue_tag), 1);
        cycle();
        checkVal("lit_add_hazard_hold", int'(o_hazard), 1);
        applyStimulus(4'd2, add6, 1'b0, 1'b1, 5'd5, 1'b0);
        cycle();
`ifdef CPU_SCOREBOARD_BYPASS_EN
        checkVal("lit_wb5_issue_tag", int'(o_issue_tag), 2);
        checkVal("lit_wb5_stall",     int'(o_stall),     0);
`else
        checkVal("lit_wb5_issue_tag", int'(o_issue_tag), 1);
        checkVal("lit_wb5_stall",     int'(o_stall),     1);
`endif
        applyStimulus(4'd2, add6, 1'b0, 1'b0, 5'd0, 1'b0);
        cycle();
        checkVal("lit_add_issued_tag", int'(o_issue_tag), 2);
        checkVal("lit_add_issued_stall", int'(o_stall),   0);
        checkVal("lit_add_pending",    int'(o_pending),   1);
        applyStimulus(4'd2, add6, 1'b0, 1'b1, 5'd6, 1'b0);
        cycle();
        checkVal("lit_wb6_pending", int'(o_pending), 0);

        // Destination saturation on x7.
        for (int t = 3; t <= 5; t++) begin
            applyStimulus(4'(t), wr7, 1'b0, 1'b0, 5'd0, 1'b0);
            cycle();
        end
        checkVal("lit_x7_pending",   int'(o_pending),   3);
        checkVal("lit_x7_issue_tag", int'(o_issue_tag), 5);
        applyStimulus(4'd6, wr7, 1'b0, 1'b0, 5'd0, 1'b0);
        cycle();
        checkVal("lit_x7_sat_stall",   int'(o_stall),   1);
        checkVal("lit_x7_sat_hazard",  int'(o_hazard),  1);
        checkVal("lit_x7_sat_pending", int'(o_pending), 3);
        applyStimulus(4'd6, wr7, 1'b0, 1'b1, 5'd7, 1'b0);
        cycle();
        checkVal("lit_x7_wb_pending", int'(o_pending), 2);
        applyStimulus(4'd6, wr7, 1'b0, 1'b0, 5'd0, 1'b0);
        cycle();
        checkVal("lit_x7_fourth_tag",     int'(o_issue_tag), 6);
        checkVal("lit_x7_fourth_pending", int'(o_pending),   3);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'd6, wr7, 1'b0, 1'b1, 5'd7, 1'b0);
            cycle();
        end
        checkVal("lit_x7_drained", int'(o_pending), 0);

        // Issue and writeback of x9 on the same edge.
        applyStimulus(4'd7, wr9, 1'b0, 1'b0, 5'd0, 1'b0);
        cycle();
        applyStimulus(4'd8, wr9, 1'b0, 1'b1, 5'd9, 1'b0);
        cycle();
        checkVal("lit_x9_same_edge_pending", int'(o_pending),   1);
        checkVal("lit_x9_same_edge_tag",     int'(o_issue_tag), 8);
        applyStimulus(4'd8, wr9, 1'b0, 1'b1, 5'd9, 1'b0);
        cycle();

        // Writeback to an idle register is sticky.
        applyStimulus(4'd8, wr9, 1'b0, 1'b1, 5'd4, 1'b0);
        cycle();
        checkVal("lit_fault_set", int'(o_fault), 1);
        applyStimulus(4'd8, wr9, 1'b0, 1'b0, 5'd0, 1'b0);
        cycle();
        checkVal("lit_fault_sticky", int'(o_fault), 1);

        // Execute busy without a hazard.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'd9, nop, 1'b1, 1'b0, 5'd0, 1'b0);
            cycle();
            checkVal("lit_busy_stall",  int'(o_stall),  1);
            checkVal("lit_busy_hazard", int'(o_hazard), 0);
        end
        applyStimulus(4'd9, nop, 1'b0, 1'b0, 5'd0, 1'b0);
        cycle();
        checkVal("lit_busy_issue_tag", int'(o_issue_tag), 9);
        checkVal("lit_busy_release",   int'(o_stall),     0);

        // Flush while waiting on a hazard with five writes outstanding.
        for (int t = 10; t <= 14; t++) begin
            applyStimulus(4'(t), mkInstr(3'b000, 0, 0, 0, t, 1'b1), 1'b0, 1'b0, 5'd0, 1'b0);
            cycle();
        end
        applyStimulus(4'd15, rd10, 1'b0, 1'b0, 5'd0, 1'b0);
        cycle();
        checkVal("lit_pre_flush_pending", int'(o_pending), 5);
        checkVal("lit_pre_flush_hazard",  int'(o_hazard),  1);
        applyStimulus(4'd15, rd10, 1'b0, 1'b0, 5'd0, 1'b1);
        cycle();
        checkVal("lit_flush_pending",   int'(o_pending),   0);
        checkVal("lit_flush_stall",     int'(o_stall),     0);
        checkVal("lit_flush_hazard",    int'(o_hazard),    0);
        checkVal("lit_flush_issue_tag", int'(o_issue_tag), 14);
        applyStimulus(4'd15, rd10, 1'b0, 1'b0, 5'd0, 1'b0);
        cycle();
        checkVal("lit_post_flush_stall", int'(o_stall),     0);
        checkVal("lit_post_flush_tag",   int'(o_issue_tag), 14);
        checkVal("lit_post_flush_fault", int'(o_fault),     1);

        // Reset while waiting on a hazard with five writes outstanding.
        for (int t = 0; t <= 4; t++) begin
            applyStimulus(4'(t), mkInstr(3'b000, 0, 0, 0, t + 10, 1'b1), 1'b0, 1'b0, 5'd0, 1'b0);
            cycle();
        end
        applyStimulus(4'd5, rd10, 1'b0, 1'b0, 5'd0, 1'b0);
        cycle();
        checkVal("lit_pre_reset_pending", int'(o_pending), 5);
        i_reset = 1'b0;
        applyStimulus(4'd0, nop, 1'b0, 1'b0, 5'd0, 1'b0);
        cycle();
        checkVal("lit_reset_pending",   int'(o_pending),   0);
        checkVal("lit_reset_stall",     int'(o_stall),     0);
        checkVal("lit_reset_issue_tag", int'(o_issue_tag), 0);
        checkVal("lit_reset_fault",     int'(o_fault),     0);
        i_reset = 1'b1;
        cycle();
        checkVal("lit_post_reset_stall", int'(o_stall),     0);
        checkVal("lit_post_reset_tag",   int'(o_issue_tag), 0);

        // Randomized traffic against the model.
        curTag = '0;
        curIns = nop;
        for (int c = 0; c < 3000; c++) begin
            if (!modelHolding && $urandom_range(0, 9) < 6) begin
                curTag = curTag + 4'd1;
                curIns = randInstr();
            end
            busy = ($urandom_range(0, 3) == 0);
            wbv  = ($urandom_range(0, 2) == 0);
            wbr  = pickWb();
            fl   = ($urandom_range(0, 59) == 0);
            applyStimulus(curTag, curIns, busy, wbv, wbr, fl);
            i_reset = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
